// File: rtl/counter_delayed_trigger.sv
// ============================================================================
// Module  : counter_delayed_trigger
// Brief   : Armable sticky trigger that fires presamples cycles before a
//           reference point of a free-running 32-bit cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_delayed_trigger (
  input  logic        clk,
  input  logic        aresetn_i,
  input  logic        arm_i,
  input  logic        trigger_reset_i,
  input  logic        counter_reset_i,
  input  logic [31:0] presamples_i,
  input  logic [31:0] reference_counter_i,
  output logic        trigger_o,
  output logic        armed_status_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] target;
  logic        trigger_q;
  logic        armed_q;

  // Saturate at zero rather than underflow when presamples reaches the reference.
  always_comb begin
    target = '0;
    if (presamples_i < reference_counter_i) begin
      target = reference_counter_i - presamples_i;
    end
  end

  always_comb begin
    count_d = count_q + 32'd1;
    if (counter_reset_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge aresetn_i) begin
    if (aresetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The compare uses count_q, i.e. the count before this edge's update.
  always_ff @(posedge clk or posedge aresetn_i) begin
    if (aresetn_i) begin
      state_q   <= ST_IDLE;
      trigger_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i && !trigger_reset_i) begin
            state_q   <= ST_ARMED;
            armed_q   <= 1'b1;
            trigger_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (trigger_reset_i) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            trigger_q <= 1'b0;
          end else if (count_q == target) begin
            state_q   <= ST_TRIGGERED;
            armed_q   <= 1'b0;
            trigger_q <= 1'b1;
          end
        end
        ST_TRIGGERED: begin
          if (trigger_reset_i) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            trigger_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          armed_q   <= 1'b0;
          trigger_q <= 1'b0;
        end
      endcase
    end
  end

  assign trigger_o      = trigger_q;
  assign armed_status_o = armed_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_delayed_trigger.sv
// ============================================================================
// Module  : tb_counter_delayed_trigger
// Brief   : Directed vector bench for counter_delayed_trigger.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_delayed_trigger;

  logic        clk;
  logic        aresetn;
  logic        arm;
  logic        trigger_reset;
  logic        counter_reset;
  logic [31:0] presamples;
  logic [31:0] reference_counter;
  logic        trigger;
  logic        armed_status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        arm;
    logic        trst;
    logic        crst;
    logic [31:0] pres;
    logic [31:0] refc;
    int          extra;
    logic        exp_trig;
    logic        exp_armed;
    logic [31:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  counter_delayed_trigger dut (
    .clk                 (clk),
    .aresetn_i           (aresetn),
    .arm_i               (arm),
    .trigger_reset_i     (trigger_reset),
    .counter_reset_i     (counter_reset),
    .presamples_i        (presamples),
    .reference_counter_i (reference_counter),
    .trigger_o           (trigger),
    .armed_status_o      (armed_status)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic et, input logic ea, input logic [31:0] ec);
    check({tag, ".trigger"}, {31'd0, trigger}, {31'd0, et});
    check({tag, ".armed_status"}, {31'd0, armed_status}, {31'd0, ea});
    check({tag, ".count"}, dut.count_q, ec);
  endtask

  task automatic pulse(input logic a, input logic tr, input logic cr);
    arm = a;
    trigger_reset = tr;
    counter_reset = cr;
    tick();
    arm = 1'b0;
    trigger_reset = 1'b0;
    counter_reset = 1'b0;
  endtask

  initial begin
    // Each row: one edge with the given pulses, then 'extra' idle edges, then check.
    // Target 200 for pres=50/ref=250, target 0 for pres=300/ref=250.
    vecs[0]  = '{0, 0, 0,  50, 250,   2, 0, 0,   3};
    vecs[1]  = '{0, 0, 1,  50, 250,   0, 0, 0,   0};
    vecs[2]  = '{0, 0, 0,  50, 250,  24, 0, 0,  25};
    vecs[3]  = '{1, 0, 0,  50, 250,   0, 0, 1,  26};
    vecs[4]  = '{0, 0, 0,  50, 250, 173, 0, 1, 200};
    vecs[5]  = '{0, 0, 0,  50, 250,   0, 1, 0, 201};
    vecs[6]  = '{0, 0, 1,  50, 250,   0, 1, 0,   0};
    vecs[7]  = '{0, 0, 0,  50, 250,   9, 1, 0,  10};
    vecs[8]  = '{0, 1, 0,  50, 250,   0, 0, 0,  11};
    vecs[9]  = '{0, 0, 0,  50, 250, 126, 0, 0, 138};
    vecs[10] = '{1, 0, 0,  50, 250,   0, 0, 1, 139};
    vecs[11] = '{0, 0, 0,  50, 250,  60, 0, 1, 200};
    vecs[12] = '{0, 0, 0,  50, 250,   0, 1, 0, 201};
    vecs[13] = '{1, 0, 0,  50, 250,   0, 1, 0, 202};
    vecs[14] = '{1, 1, 0,  50, 250,   0, 0, 0, 203};
    vecs[15] = '{1, 1, 0,  50, 250,   0, 0, 0, 204};
    vecs[16] = '{1, 0, 0, 300, 250,   0, 0, 1, 205};
    vecs[17] = '{0, 0, 0, 300, 250,   4, 0, 1, 210};
    vecs[18] = '{0, 0, 1, 300, 250,   0, 0, 1,   0};
    vecs[19] = '{0, 0, 0, 300, 250,   0, 1, 0,   1};

    aresetn           = 1'b1;
    arm               = 1'b0;
    trigger_reset     = 1'b0;
    counter_reset     = 1'b0;
    presamples        = 32'd50;
    reference_counter = 32'd250;

    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 32'd0);
    aresetn = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      presamples        = vecs[i].pres;
      reference_counter = vecs[i].refc;
      pulse(vecs[i].arm, vecs[i].trst, vecs[i].crst);
      repeat (vecs[i].extra) tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_trig, vecs[i].exp_armed, vecs[i].exp_cnt);
    end

    // counter_reset on the very edge that samples count==target still fires.
    presamples        = 32'd0;
    reference_counter = 32'd5;
    pulse(1'b0, 1'b1, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("cr_arm", 1'b0, 1'b1, 32'd1);
    repeat (4) tick();
    check_all("cr_pre", 1'b0, 1'b1, 32'd5);
    pulse(1'b0, 1'b0, 1'b1);
    check_all("cr_fire", 1'b1, 1'b0, 32'd0);

    // presamples == reference saturates to 0; the arming edge must not compare.
    presamples        = 32'd7;
    reference_counter = 32'd7;
    pulse(1'b0, 1'b1, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check_all("eq_arm", 1'b0, 1'b1, 32'd1);
    pulse(1'b0, 1'b0, 1'b1);
    check_all("eq_clr", 1'b0, 1'b1, 32'd0);
    tick();
    check_all("eq_fire", 1'b1, 1'b0, 32'd1);

    // Asynchronous reset while ARMED drops outputs before the next edge.
    presamples        = 32'd300;
    reference_counter = 32'd250;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check({"async_pre", ".armed_status"}, {31'd0, armed_status}, 32'd1);
    #2;
    aresetn = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 32'd0);
    #1;
    aresetn = 1'b0;
    repeat (5) tick();
    check_all("async_after", 1'b0, 1'b0, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
